// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch: PC, credit-limited imem requests, instruction buffer
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect halts fetch and raises sticky fetch_fault.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [63:0] instr_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_next;

  logic             started;
  logic [63:0]      fetch_pc, rsp_pc, target_pc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, outstanding, discard, outstanding_next;
  logic [CNT_W:0]   credit_used;
  logic [63:0]      pc_mem   [FIFO_DEPTH];
  logic [31:0]      word_mem [FIFO_DEPTH];
  logic             gnt_fire, push, pop, misaligned;

  assign target_pc = redirect_pc & ~64'h3;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A same-cycle pop frees its slot, so zero-wait memory sustains one word per cycle.
  assign pop         = instr_valid && instr_ready && !redirect;
  assign credit_used = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {1'b0, outstanding};

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      RUN: begin
        imem_req = started && !redirect && (credit_used < DEPTH_V);
        if (misaligned) state_next = HALT;
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  assign gnt_fire         = imem_req && imem_gnt;
  assign push             = imem_rvalid && (discard == '0) && !redirect && (state == RUN);
  assign outstanding_next = outstanding + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      started     <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        discard  <= outstanding_next;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + 64'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 64'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (imem_rvalid && (discard != '0)) discard <= discard - CNT_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else if (misaligned) fault_q <= 1'b1;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? word_mem[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : 64'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Honours IFETCH_ALIGN_CHECK_EN when the build defines it.
module tb_instr_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [63:0] imem_addr, instr_pc, redirect_pc = 64'h0;
  logic [31:0] imem_rdata = 32'h0, instruction;
  logic        instr_valid, instr_ready = 1'b0, redirect = 1'b0, fetch_fault;

  int checks = 0, errors = 0;
  int cyc = 0, rsp_delay = 1, grants = 0;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] log_pc[$];
  logic [31:0] log_word[$];
  int          log_cyc[$];

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  // Memory with configurable response delay, plus consumption monitor.
  always @(posedge clk) begin
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + rsp_delay);
        grants++;
      end
      if (instr_valid && instr_ready && !redirect) begin
        log_pc.push_back(instr_pc);
        log_word.push_back(instruction);
        log_cyc.push_back(cyc);
      end
    end
    cyc++;
    #1;
    if (rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      pend_addr.pop_front();
      pend_due.pop_front();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_word.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0; imem_gnt = 1'b1; rsp_delay = 1;
    mid();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    tick();
    rst = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    mid();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL reset_nop: got %h expected 00000013", instruction); end
    checks++; if (instr_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
    tick();
    mid();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_stream();
    int a0;
    logic [63:0] e;
    do_reset();
    instr_ready = 1'b1;
    tick();
    a0 = cyc;
    repeat (8) tick();
    checks++;
    if (log_pc.size() < 5) begin
      errors++; $display("FAIL stream_count: got %0d expected >=5", log_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        e = RST_PC + 64'(4 * i);
        checks++; if (log_pc[i] !== e) begin errors++; $display("FAIL stream_pc%0d: got %h expected %h", i, log_pc[i], e); end
        checks++; if (log_word[i] !== mem_word(e)) begin errors++; $display("FAIL stream_word%0d: got %h expected %h", i, log_word[i], mem_word(e)); end
        checks++; if (log_cyc[i] !== a0 + 2 + i) begin errors++; $display("FAIL stream_cyc%0d: got %0d expected %0d", i, log_cyc[i], a0 + 2 + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int g0, n0, bad;
    g0 = grants;
    instr_ready = 1'b0;
    repeat (10) tick();
    mid();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
    checks++; if (grants - g0 > DEPTH) begin errors++; $display("FAIL bp_grants: got %0d expected <=%0d", grants - g0, DEPTH); end
    n0 = log_pc.size();
    tick();
    instr_ready = 1'b1;
    repeat (8) tick();
    checks++; if (log_pc.size() < n0 + 4) begin errors++; $display("FAIL bp_resume: got %0d expected >=%0d", log_pc.size(), n0 + 4); end
    bad = 0;
    for (int i = 1; i < log_pc.size(); i++)
      if (log_pc[i] !== log_pc[i-1] + 64'd4 || log_word[i] !== mem_word(log_pc[i])) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_continuity: got %0d breaks expected 0", bad); end
  endtask

  task automatic test_redirect_inflight();
    int w;
    do_reset();
    rsp_delay = 3;
    tick();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 64'h2000; instr_ready = 1'b1;
    mid();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req: got %b expected 0", imem_req); end
    tick();
    redirect = 1'b0;
    clear_log();
    mid();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_flushed: got %b expected 0", instr_valid); end
    w = 0;
    while (log_pc.size() < 2 && w < 30) begin tick(); w++; end
    checks++;
    if (log_pc.size() < 2) begin
      errors++; $display("FAIL rd_timeout: got %0d words expected 2", log_pc.size());
    end else begin
      if (log_pc[0] !== 64'h2000 || log_word[0] !== mem_word(64'h2000) || log_pc[1] !== 64'h2004) begin
        errors++; $display("FAIL rd_target: got %h,%h expected 2000,2004", log_pc[0], log_pc[1]);
      end
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    imem_gnt = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mid();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
        errors++; $display("FAIL stall_addr%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, RST_PC);
      end
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    mid();
    checks++; if (imem_addr !== RST_PC + 64'd4) begin errors++; $display("FAIL stall_adv: got %h expected %h", imem_addr, RST_PC + 64'd4); end
  endtask

  task automatic test_wrap();
    int r;
    logic [63:0] e;
    do_reset();
    instr_ready = 1'b1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    r = cyc;
    tick();
    redirect = 1'b0;
    clear_log();
    mid();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffffffffff8", imem_req, imem_addr);
    end
    tick();
    tick();
    mid();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++; $display("FAIL wrap_lat: got valid=%b pc=%h expected valid=1 pc=fffffffffffffff8", instr_valid, instr_pc);
    end
    repeat (4) tick();
    checks++;
    if (log_pc.size() < 4) begin
      errors++; $display("FAIL wrap_count: got %0d expected >=4", log_pc.size());
    end else begin
      checks++; if (log_cyc[0] !== r + 3) begin errors++; $display("FAIL wrap_cyc: got %0d expected %0d", log_cyc[0], r + 3); end
      for (int i = 0; i < 4; i++) begin
        e = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i);
        checks++; if (log_pc[i] !== e) begin errors++; $display("FAIL wrap_pc%0d: got %h expected %h", i, log_pc[i], e); end
      end
    end
  endtask

  task automatic test_misalign();
`ifdef IFETCH_ALIGN_CHECK_EN
    int bad;
`endif
    do_reset();
    instr_ready = 1'b1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 64'h2002;
    tick();
    redirect = 1'b0;
    clear_log();
`ifdef IFETCH_ALIGN_CHECK_EN
    mid();
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", fetch_fault); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mis_halt: got %0d bad cycles expected 0", bad); end
    do_reset();
    mid();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", fetch_fault); end
`else
    mid();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mis_fault: got %b expected 0", fetch_fault); end
    repeat (6) tick();
    checks++;
    if (log_pc.size() < 1) begin
      errors++; $display("FAIL mis_count: got %0d expected >=1", log_pc.size());
    end else if (log_pc[0] !== 64'h2000 || log_word[0] !== mem_word(64'h2000)) begin
      errors++; $display("FAIL mis_target: got %h expected 2000", log_pc[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_gnt_stall();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
